tff_arbiter: RTL and testbench
==============================

TFF_ARBITER -- requirements
Module: tff_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing one T flip-flop.
REQ-002 Parameter NTOG, default 1, range 1..7, t pulses (toggle cycles) issued per grant.
REQ-003 c  input  1  clock, all state updates on rising edge.
REQ-004 r  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  per-requester toggle request, level, held until done or withdrawn.
REQ-006 q_in  input  1  q output of the shared T flip-flop.
REQ-007 t_out  output  1  drives t input of the shared T flip-flop.
REQ-008 gnt  output  NREQ  one-hot grant, registered.
REQ-009 done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-010 q_snap  output  1  q_in captured at end of each completed grant.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, GRANT, SETTLE, DONE; encoding is binary, 2 bits.
REQ-013 IDLE: if any req bit set, select winner round-robin starting at index last+1 mod NREQ, register gnt one-hot, load toggle counter with NTOG, go to GRANT next edge.
REQ-014 IDLE with req all zero: stay IDLE, gnt=0, t_out=0.
REQ-015 GRANT: t_out=1 every cycle, counter decrements each edge; at count 1 go to SETTLE, so t_out is high exactly NTOG consecutive cycles.
REQ-016 SETTLE: t_out=0, one cycle; q_snap<=q_in on the edge leaving SETTLE; go to DONE.
REQ-017 DONE: done[winner]=1 for exactly one cycle, gnt still asserted; next edge gnt<=0, last<=winner, go to IDLE.
REQ-018 Latency: req sampled high at edge k (IDLE) gives gnt and t_out high from k+1, done high in cycle k+NTOG+2, busy low from k+NTOG+3.
REQ-019 Withdrawal: req[winner] low during GRANT or SETTLE aborts: next edge gnt<=0, t_out<=0, no done pulse, q_snap unchanged, last<=winner, go IDLE.
REQ-020 Withdrawal in DONE is ignored; done pulse still issued.
REQ-021 Requests other than winner are ignored while busy; they are held by requesters and arbitrated on return to IDLE.
REQ-022 Round-robin wrap: after winner NREQ-1, search starts at 0; no requester waits more than NREQ-1 grants.
REQ-023 Minimum gap: at least one IDLE cycle between consecutive grants; gnt never carries more than one bit.
REQ-024 Net effect on shared flop per completed grant: q toggles NTOG times (odd NTOG inverts q).

Reset
REQ-025 r high at edge: state<=IDLE, gnt<=0, done<=0, t_out<=0, q_snap<=0, busy<=0, last<=NREQ-1 (so index 0 wins first), counter<=0.
REQ-026 r mid-grant overrides all: no done pulse issued, t_out low from next cycle.
REQ-027 r takes priority over req and withdrawal in the same cycle.

Structure
REQ-028 Shared package holds FSM state encoding, NREQ default, NTOG default, counter width (3).
REQ-029 One sub-module rr_pick: combinational round-robin picker, inputs req and last, output one-hot winner and index.
REQ-030 All outputs registered; no combinational path req->gnt or q_in->q_snap.

Verification
REQ-031 NTOG=1, q_in from bench T-flop model starting q=0, req=0001 at edge 5 -> gnt=0001 edges 6-8, t_out high cycle 6 only, done[0] cycle 8, q_snap=1.
REQ-032 NTOG=2, req=0100 -> t_out high two cycles, done[2] at k+4, q_snap equals initial q (0).
REQ-033 req=1111 held, NTOG=1 -> grant order 0,1,2,3,0, one IDLE cycle between grants, never two gnt bits.
REQ-034 req=0010 then withdrawn in GRANT (NTOG=3, second cycle) -> gnt=0 and t_out=0 next cycle, no done[1], q_snap unchanged, next grant starts search at 2.
REQ-035 r asserted during SETTLE -> next cycle state IDLE, all outputs 0, no done pulse; after release req=1000,0001 -> index 0 granted first.
REQ-036 req changed on non-winner bits during GRANT -> no effect on current grant; pending bit granted after return to IDLE.

Source files
------------

// File: rtl/tff_arbiter_pkg.sv
// Shared types and defaults for the T flip-flop arbiter.
package tff_arbiter_pkg;

  localparam int unsigned NreqDefault = 4;
  localparam int unsigned NtogDefault = 1;
  localparam int unsigned CntW        = 3;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrant  = 2'd1,
    StSettle = 2'd2,
    StDone   = 2'd3
  } state_e;

endpackage

// File: rtl/tff_arbiter_if.sv
// Requester and shared-flop signals of the T flip-flop arbiter.
interface tff_arbiter_if #(
  parameter int unsigned NREQ = tff_arbiter_pkg::NreqDefault
) ();

  logic [NREQ-1:0] req;
  logic            q_in;
  logic            t_out;
  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] done;
  logic            q_snap;
  logic            busy;

  modport slave (
    input  req,
    input  q_in,
    output t_out,
    output gnt,
    output done,
    output q_snap,
    output busy
  );

  modport master (
    output req,
    output q_in,
    input  t_out,
    input  gnt,
    input  done,
    input  q_snap,
    input  busy
  );

endinterface

// File: rtl/tff_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after index 'last', wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] last,
  output logic [NREQ-1:0] winner,
  output logic [IdxW-1:0] index
);

  int unsigned j;
  logic [IdxW-1:0] j_idx;
  logic found;

  always_comb begin
    winner = '0;
    index  = '0;
    found  = 1'b0;
    j      = 0;
    j_idx  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      j     = (32'(last) + i) % NREQ;
      j_idx = IdxW'(j);
      if (!found && req[j_idx]) begin
        found         = 1'b1;
        winner[j_idx] = 1'b1;
        index         = j_idx;
      end
    end
  end

endmodule

// File: rtl/tff_arbiter.sv
// Round-robin arbiter granting NREQ requesters NTOG toggles of one shared T flip-flop.
module tff_arbiter
  import tff_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = NreqDefault,
  parameter int unsigned NTOG = NtogDefault
) (
  input  logic          c,
  input  logic          r,
  tff_arbiter_if.slave  bus
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic [NREQ-1:0] pick_oh;
  logic [IdxW-1:0] last_q, last_d;
  logic [IdxW-1:0] win_q, win_d;
  logic [IdxW-1:0] pick_idx;
  logic            t_q, t_d;
  logic            snap_q, snap_d;
  logic            busy_q, busy_d;
  logic            withdrawn;

  rr_pick #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req    (bus.req),
    .last   (last_q),
    .winner (pick_oh),
    .index  (pick_idx)
  );

  assign withdrawn = !bus.req[win_q];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    last_d  = last_q;
    win_d   = win_q;
    t_d     = t_q;
    snap_d  = snap_q;
    unique case (state_q)
      StIdle: begin
        gnt_d = '0;
        t_d   = 1'b0;
        if (|bus.req) begin
          state_d = StGrant;
          gnt_d   = pick_oh;
          win_d   = pick_idx;
          cnt_d   = CntW'(NTOG);
          t_d     = 1'b1;
        end
      end
      StGrant: begin
        if (withdrawn) begin
          state_d = StIdle;
          gnt_d   = '0;
          t_d     = 1'b0;
          last_d  = win_q;
        end else if (cnt_q == CntW'(1)) begin
          state_d = StSettle;
          t_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StSettle: begin
        // Flop output has had a full cycle to settle after the last toggle.
        if (withdrawn) begin
          state_d = StIdle;
          gnt_d   = '0;
          last_d  = win_q;
        end else begin
          state_d = StDone;
          snap_d  = bus.q_in;
          done_d  = gnt_q;
        end
      end
      StDone: begin
        state_d = StIdle;
        gnt_d   = '0;
        last_d  = win_q;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge c) begin
    if (r) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      last_q  <= IdxW'(NREQ - 1);
      win_q   <= '0;
      t_q     <= 1'b0;
      snap_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      last_q  <= last_d;
      win_q   <= win_d;
      t_q     <= t_d;
      snap_q  <= snap_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.t_out  = t_q;
  assign bus.gnt    = gnt_q;
  assign bus.done   = done_q;
  assign bus.q_snap = snap_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_tff_arbiter.sv
// Bench: three arbiters (NTOG=1,2,3) each driving its own T flip-flop model.
module tb_tff_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req_a  [3];
  logic [3:0] gnt_a  [3];
  logic [3:0] done_a [3];
  logic [2:0] t_v, snap_v, busy_v, q_v;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    tff_arbiter_if #(.NREQ(4)) bus ();
    logic q;

    tff_arbiter #(
      .NREQ (4),
      .NTOG (g + 1)
    ) dut (
      .c   (clk),
      .r   (rst),
      .bus (bus)
    );

    assign bus.req   = req_a[g];
    assign bus.q_in  = q;
    assign gnt_a[g]  = bus.gnt;
    assign done_a[g] = bus.done;
    assign t_v[g]    = bus.t_out;
    assign snap_v[g] = bus.q_snap;
    assign busy_v[g] = bus.busy;
    assign q_v[g]    = q;

    always @(posedge clk) begin
      if (rst) q <= 1'b0;
      else if (bus.t_out) q <= ~q;
    end
  end

  typedef struct {
    logic [3:0] req;
    logic [3:0] gnt;
    logic       t;
    logic [3:0] done;
    logic       busy;
    logic       snap;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int d = 0; d < 3; d++) req_a[d] = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int rr(input logic [3:0] r, input int last);
    for (int i = 1; i <= 4; i++) begin
      int idx;
      idx = (last + i) % 4;
      if (((r >> idx) & 4'd1) != 0) return idx;
    end
    return -1;
  endfunction

  // Transaction-level reference: a grant occupies cycles 1..NTOG+2 after the sampling edge.
  bit   m_active [3];
  int   m_off    [3];
  int   m_win    [3];
  int   m_last   [3];
  logic m_snap   [3];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int         tcount, done_at, ntog;
    logic [3:0] done_val, done_or, w;
    logic       snap_seen;

    for (int d = 0; d < 3; d++) req_a[d] = 4'b0000;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < 3; d++) begin
      check("reset_gnt", d, 32'(gnt_a[d]), 0);
      check("reset_t", d, 32'(t_v[d]), 0);
      check("reset_done", d, 32'(done_a[d]), 0);
      check("reset_busy", d, 32'(busy_v[d]), 0);
      check("reset_snap", d, 32'(snap_v[d]), 0);
    end

    // All requesters held, NTOG=1: grants 0,1,2,3,0 with an idle cycle between.
    for (int g = 0; g < 5; g++) begin
      w = 4'b0001 << (g % 4);
      tbl.push_back('{4'hF, w, 1'b1, 4'h0, 1'b1, 1'(g % 2)});
      tbl.push_back('{4'hF, w, 1'b0, 4'h0, 1'b1, 1'(g % 2)});
      tbl.push_back('{4'hF, w, 1'b0, w,    1'b1, 1'((g + 1) % 2)});
      tbl.push_back('{4'hF, 4'h0, 1'b0, 4'h0, 1'b0, 1'((g + 1) % 2)});
    end
    foreach (tbl[i]) begin
      req_a[0] = tbl[i].req;
      @(negedge clk);
      check($sformatf("tbl%0d_gnt", i), 0, 32'(gnt_a[0]), 32'(tbl[i].gnt));
      check($sformatf("tbl%0d_t", i), 0, 32'(t_v[0]), 32'(tbl[i].t));
      check($sformatf("tbl%0d_done", i), 0, 32'(done_a[0]), 32'(tbl[i].done));
      check($sformatf("tbl%0d_busy", i), 0, 32'(busy_v[0]), 32'(tbl[i].busy));
      check($sformatf("tbl%0d_snap", i), 0, 32'(snap_v[0]), 32'(tbl[i].snap));
    end

    // NTOG=2, single request on index 2.
    do_reset();
    req_a[1] = 4'b0100;
    tcount = 0; done_at = 0; done_val = 4'b0; snap_seen = 1'b1;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      if (j == 1) check("n2_gnt", 1, 32'(gnt_a[1]), 32'h4);
      if (t_v[1]) tcount++;
      if (done_a[1] != 4'b0) begin
        done_at  = j;
        done_val = done_a[1];
      end
      if (j == 4) begin
        snap_seen = snap_v[1];
        req_a[1]  = 4'b0000;
      end
      if (j == 5) check("n2_busy_low", 1, 32'(busy_v[1]), 0);
    end
    check("n2_t_cycles", 1, 32'(tcount), 2);
    check("n2_done_cycle", 1, 32'(done_at), 4);
    check("n2_done_val", 1, 32'(done_val), 32'h4);
    check("n2_snap", 1, 32'(snap_seen), 0);

    // NTOG=3, withdrawal in second GRANT cycle.
    do_reset();
    req_a[2] = 4'b0010;
    @(negedge clk);
    check("wd_gnt", 2, 32'(gnt_a[2]), 32'h2);
    @(negedge clk);
    check("wd_t2", 2, 32'(t_v[2]), 1);
    req_a[2] = 4'b0000;
    @(negedge clk);
    check("wd_gnt_off", 2, 32'(gnt_a[2]), 0);
    check("wd_t_off", 2, 32'(t_v[2]), 0);
    check("wd_busy_off", 2, 32'(busy_v[2]), 0);
    done_or = done_a[2];
    repeat (3) begin
      @(negedge clk);
      done_or |= done_a[2];
    end
    check("wd_no_done", 2, 32'(done_or), 0);
    check("wd_snap", 2, 32'(snap_v[2]), 0);
    req_a[2] = 4'b0110;
    @(negedge clk);
    check("wd_next_from2", 2, 32'(gnt_a[2]), 32'h4);

    // Reset during SETTLE, then 1000/0001 together: index 0 first.
    do_reset();
    req_a[0] = 4'b1000;
    @(negedge clk);
    check("rs_gnt", 0, 32'(gnt_a[0]), 32'h8);
    @(negedge clk);
    check("rs_settle_t", 0, 32'(t_v[0]), 0);
    rst = 1'b1;
    @(negedge clk);
    check("rs_gnt0", 0, 32'(gnt_a[0]), 0);
    check("rs_done0", 0, 32'(done_a[0]), 0);
    check("rs_busy0", 0, 32'(busy_v[0]), 0);
    check("rs_t0", 0, 32'(t_v[0]), 0);
    rst = 1'b0;
    req_a[0] = 4'b1001;
    @(negedge clk);
    check("rs_first", 0, 32'(gnt_a[0]), 32'h1);
    @(negedge clk);
    @(negedge clk);
    check("rs_done_first", 0, 32'(done_a[0]), 32'h1);
    req_a[0] = 4'b1000;
    @(negedge clk);
    check("rs_gap", 0, 32'(gnt_a[0]), 0);
    @(negedge clk);
    check("rs_second", 0, 32'(gnt_a[0]), 32'h8);

    // NTOG=3, non-winner bits changing during the grant.
    do_reset();
    req_a[2] = 4'b0001;
    @(negedge clk);
    check("nw_gnt", 2, 32'(gnt_a[2]), 32'h1);
    req_a[2] = 4'b1011;
    for (int j = 2; j <= 5; j++) begin
      @(negedge clk);
      check($sformatf("nw_hold%0d", j), 2, 32'(gnt_a[2]), 32'h1);
    end
    check("nw_done", 2, 32'(done_a[2]), 32'h1);
    check("nw_snap", 2, 32'(snap_v[2]), 1);
    req_a[2] = 4'b1010;
    @(negedge clk);
    check("nw_idle", 2, 32'(busy_v[2]), 0);
    @(negedge clk);
    check("nw_pending", 2, 32'(gnt_a[2]), 32'h2);

    // Random requesters holding until done, against the reference model.
    do_reset();
    for (int d = 0; d < 3; d++) begin
      m_active[d] = 1'b0;
      m_off[d]    = 0;
      m_win[d]    = 0;
      m_last[d]   = 3;
      m_snap[d]   = 1'b0;
    end
    repeat (800) begin
      for (int d = 0; d < 3; d++) begin
        logic [3:0] eg, ed;
        logic       et;
        ntog = d + 1;
        eg = m_active[d] ? (4'b0001 << m_win[d]) : 4'b0000;
        et = m_active[d] && (m_off[d] <= ntog);
        ed = (m_active[d] && m_off[d] == ntog + 2) ? eg : 4'b0000;
        check("rnd_gnt", d, 32'(gnt_a[d]), 32'(eg));
        check("rnd_t", d, 32'(t_v[d]), 32'(et));
        check("rnd_done", d, 32'(done_a[d]), 32'(ed));
        check("rnd_busy", d, 32'(busy_v[d]), 32'(m_active[d]));
        check("rnd_snap", d, 32'(snap_v[d]), 32'(m_snap[d]));
        if (ed != 4'b0000) req_a[d][m_win[d]] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (!(m_active[d] && i == m_win[d]) && !req_a[d][i] && $urandom_range(0, 5) == 0)
            req_a[d][i] = 1'b1;
        end
        if (m_active[d]) begin
          if (m_off[d] == ntog + 2) begin
            m_active[d] = 1'b0;
            m_last[d]   = m_win[d];
          end else begin
            if (m_off[d] == ntog + 1) m_snap[d] = q_v[d];
            m_off[d]++;
          end
        end else if (req_a[d] != 4'b0000) begin
          m_win[d]    = rr(req_a[d], m_last[d]);
          m_active[d] = 1'b1;
          m_off[d]    = 1;
        end
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
